// File: rtl/seg7_rx_decoder.sv
// Receive-side 7-segment decoder: debounces the sampled segment bus, decodes it
// back to BCD, flags illegal patterns and keeps a saturating error count.
//
// state    | meaning
// EMPTY    | nothing sampled since reset
// SETTLING | candidate differs from the accepted pattern, counting stable samples
// LOCKED   | candidate accepted, outputs reflect it
module seg7_rx_decoder #(
    parameter int unsigned STABLE_CNT = 4
) (
    input  logic       clk_50,
    input  logic       clr,
    input  logic [6:0] seg_in,
    input  logic       sample_en,
    output logic [3:0] digit,
    output logic       valid,
    output logic       err,
    output logic       new_digit,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        SETTLING = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    localparam logic [3:0] STAB_TGT = 4'(STABLE_CNT);

    state_t     state_q, state_d;
    logic [6:0] cand_q, cand_d;
    logic [3:0] stab_q, stab_d;
    logic [3:0] digit_d;
    logic       valid_d, err_d, new_digit_d;
    logic [7:0] err_count_d;
    logic       accept;

    logic       dec_legal, dec_blank;
    logic [3:0] dec_code;

    always_comb begin
        dec_legal = 1'b1;
        dec_blank = 1'b0;
        dec_code  = 4'd0;
        case (seg_in)
            7'h3F: dec_code = 4'd0;
            7'h06: dec_code = 4'd1;
            7'h5B: dec_code = 4'd2;
            7'h4F: dec_code = 4'd3;
            7'h66: dec_code = 4'd4;
            7'h6D: dec_code = 4'd5;
            7'h7D: dec_code = 4'd6;
            7'h07: dec_code = 4'd7;
            7'h7F: dec_code = 4'd8;
            7'h6F: dec_code = 4'd9;
            7'h00: begin
                dec_legal = 1'b0;
                dec_blank = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk_50 or negedge clr) begin
        if (!clr) begin
            state_q   <= EMPTY;
            cand_q    <= 7'd0;
            stab_q    <= 4'd0;
            digit     <= 4'd0;
            valid     <= 1'b0;
            err       <= 1'b0;
            new_digit <= 1'b0;
            err_count <= 8'd0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            stab_q    <= stab_d;
            digit     <= digit_d;
            valid     <= valid_d;
            err       <= err_d;
            new_digit <= new_digit_d;
            err_count <= err_count_d;
        end
    end

    // Acceptance always happens on the sample that completes the run, so the
    // pattern being accepted is the current seg_in.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        stab_d  = stab_q;
        accept  = 1'b0;
        if (sample_en) begin
            case (state_q)
                EMPTY: begin
                    cand_d = seg_in;
                    stab_d = 4'd1;
                    if (STAB_TGT == 4'd1) begin
                        accept  = 1'b1;
                        state_d = LOCKED;
                    end else begin
                        state_d = SETTLING;
                    end
                end
                SETTLING: begin
                    if (seg_in == cand_q) begin
                        stab_d = stab_q + 4'd1;
                        if (stab_q + 4'd1 == STAB_TGT) begin
                            accept  = 1'b1;
                            state_d = LOCKED;
                        end
                    end else begin
                        cand_d = seg_in;
                        stab_d = 4'd1;
                        if (STAB_TGT == 4'd1) begin
                            accept  = 1'b1;
                            state_d = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (seg_in != cand_q) begin
                        cand_d = seg_in;
                        stab_d = 4'd1;
                        if (STAB_TGT == 4'd1) accept = 1'b1;
                        else state_d = SETTLING;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    cand_d  = 7'd0;
                    stab_d  = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        digit_d     = digit;
        valid_d     = valid;
        err_d       = err;
        new_digit_d = 1'b0;
        err_count_d = err_count;
        if (accept) begin
            if (dec_legal) begin
                digit_d     = dec_code;
                valid_d     = 1'b1;
                err_d       = 1'b0;
                new_digit_d = !valid || (dec_code != digit);
            end else if (dec_blank) begin
                valid_d = 1'b0;
                err_d   = 1'b0;
            end else begin
                valid_d = 1'b0;
                err_d   = 1'b1;
                if (err_count != 8'hFF) err_count_d = err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_rx_decoder.sv
// Bench for seg7_rx_decoder: directed sequences and a decode vector table on a
// STABLE_CNT=4 instance, a STABLE_CNT=1 instance, and random stimulus vs a run-length model.
module tb_seg7_rx_decoder;

    logic       clk_50 = 1'b0;
    logic       clr = 1'b0;
    logic [6:0] seg_in = 7'd0;
    logic       sample_en = 1'b0;

    logic [3:0] d4_digit, d1_digit;
    logic       d4_valid, d1_valid, d4_err, d1_err, d4_nd, d1_nd;
    logic [7:0] d4_cnt, d1_cnt;

    seg7_rx_decoder #(.STABLE_CNT(4)) u_dut4 (
        .clk_50(clk_50), .clr(clr), .seg_in(seg_in), .sample_en(sample_en),
        .digit(d4_digit), .valid(d4_valid), .err(d4_err),
        .new_digit(d4_nd), .err_count(d4_cnt)
    );

    seg7_rx_decoder #(.STABLE_CNT(1)) u_dut1 (
        .clk_50(clk_50), .clr(clr), .seg_in(seg_in), .sample_en(sample_en),
        .digit(d1_digit), .valid(d1_valid), .err(d1_err),
        .new_digit(d1_nd), .err_count(d1_cnt)
    );

    always #5 clk_50 = ~clk_50;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input logic [6:0] s, input logic en);
        @(negedge clk_50);
        seg_in    = s;
        sample_en = en;
        @(posedge clk_50);
        #1;
    endtask

    // Reference model: a pattern is accepted when its run of consecutive
    // identical samples reaches exactly the required length.
    logic [6:0] codes [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    int         need [2] = '{4, 1};
    int         run [2];
    logic [6:0] last [2];
    int         m_digit [2];
    int         m_valid [2];
    int         m_err [2];
    int         m_nd [2];
    int         m_cnt [2];

    initial begin
        forever begin
            @(posedge clk_50 or negedge clr);
            for (int i = 0; i < 2; i++) begin
                if (!clr) begin
                    run[i] = 0; last[i] = 7'd0;
                    m_digit[i] = 0; m_valid[i] = 0; m_err[i] = 0; m_nd[i] = 0; m_cnt[i] = 0;
                end else begin
                    m_nd[i] = 0;
                    if (sample_en) begin
                        if (run[i] > 0 && seg_in == last[i]) run[i]++;
                        else begin
                            last[i] = seg_in;
                            run[i] = 1;
                        end
                        if (run[i] == need[i]) begin
                            int idx;
                            idx = -1;
                            for (int k = 0; k < 10; k++) if (codes[k] == seg_in) idx = k;
                            if (idx >= 0) begin
                                m_nd[i] = (m_valid[i] == 0 || m_digit[i] != idx) ? 1 : 0;
                                m_digit[i] = idx; m_valid[i] = 1; m_err[i] = 0;
                            end else if (seg_in == 7'h00) begin
                                m_valid[i] = 0; m_err[i] = 0;
                            end else begin
                                m_valid[i] = 0; m_err[i] = 1;
                                if (m_cnt[i] < 255) m_cnt[i]++;
                            end
                        end
                    end
                end
            end
        end
    end

    typedef struct {
        logic [6:0] seg;
        int         digit;
        int         valid;
        int         err;
        int         nd;
    } vec_t;

    vec_t vecs [14];

    logic [6:0] pool [14] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D,
                              7'h07, 7'h7F, 7'h6F, 7'h00, 7'h49, 7'h41, 7'h12};

    initial begin
        vecs[0]  = '{7'h3F, 0, 1, 0, 1};
        vecs[1]  = '{7'h06, 1, 1, 0, 1};
        vecs[2]  = '{7'h5B, 2, 1, 0, 1};
        vecs[3]  = '{7'h4F, 3, 1, 0, 1};
        vecs[4]  = '{7'h66, 4, 1, 0, 1};
        vecs[5]  = '{7'h6D, 5, 1, 0, 1};
        vecs[6]  = '{7'h7D, 6, 1, 0, 1};
        vecs[7]  = '{7'h07, 7, 1, 0, 1};
        vecs[8]  = '{7'h7F, 8, 1, 0, 1};
        vecs[9]  = '{7'h6F, 9, 1, 0, 1};
        vecs[10] = '{7'h00, 9, 0, 0, 0};
        vecs[11] = '{7'h49, 9, 0, 1, 0};
        vecs[12] = '{7'h3F, 0, 1, 0, 1};
        vecs[13] = '{7'h3F, 0, 1, 0, 0};

        #12;
        chk("reset digit", d4_digit, 0);
        chk("reset valid", d4_valid, 0);
        chk("reset err", d4_err, 0);
        chk("reset new_digit", d4_nd, 0);
        chk("reset err_count", d4_cnt, 0);
        @(negedge clk_50);
        clr = 1'b1;

        for (int t = 0; t < 3; t++) tick(7'h5B, 1'b1);
        chk("latency valid before 4th tick", d4_valid, 0);
        tick(7'h5B, 1'b1);
        chk("first digit", d4_digit, 2);
        chk("first valid", d4_valid, 1);
        chk("first err", d4_err, 0);
        chk("first new_digit", d4_nd, 1);
        chk("first err_count", d4_cnt, 0);
        tick(7'h5B, 1'b0);
        chk("new_digit one cycle", d4_nd, 0);

        for (int t = 0; t < 11; t++) begin
            tick((t < 3) ? 7'h4F : 7'h5B, 1'b1);
            chk($sformatf("glitch no new_digit t%0d", t), d4_nd, 0);
            chk($sformatf("glitch hold digit t%0d", t), d4_digit, 2);
            chk($sformatf("glitch hold valid t%0d", t), d4_valid, 1);
        end

        for (int t = 0; t < 4; t++) tick(7'h49, 1'b1);
        chk("illegal valid", d4_valid, 0);
        chk("illegal err", d4_err, 1);
        chk("illegal count", d4_cnt, 1);
        chk("illegal digit hold", d4_digit, 2);
        for (int t = 0; t < 10; t++) tick(7'h49, 1'b1);
        chk("illegal held count", d4_cnt, 1);
        for (int t = 0; t < 4; t++) tick(7'h00, 1'b1);
        chk("blank err", d4_err, 0);
        chk("blank valid", d4_valid, 0);

        foreach (vecs[v]) begin
            for (int t = 0; t < 4; t++) tick(vecs[v].seg, 1'b1);
            chk($sformatf("vec%0d digit", v), d4_digit, vecs[v].digit);
            chk($sformatf("vec%0d valid", v), d4_valid, vecs[v].valid);
            chk($sformatf("vec%0d err", v), d4_err, vecs[v].err);
            chk($sformatf("vec%0d new_digit", v), d4_nd, vecs[v].nd);
        end
        chk("vec err_count", d4_cnt, 2);

        for (int a = 0; a < 260; a++)
            for (int t = 0; t < 4; t++) tick(a[0] ? 7'h41 : 7'h49, 1'b1);
        chk("err_count saturates", d4_cnt, 255);

        for (int t = 0; t < 3; t++) tick(7'h07, 1'b1);
        @(negedge clk_50);
        sample_en = 1'b0;
        #2 clr = 1'b0;
        #1;
        chk("async clr digit", d4_digit, 0);
        chk("async clr valid", d4_valid, 0);
        chk("async clr err", d4_err, 0);
        chk("async clr new_digit", d4_nd, 0);
        chk("async clr err_count", d4_cnt, 0);
        @(negedge clk_50);
        clr = 1'b1;
        for (int t = 0; t < 3; t++) tick(7'h07, 1'b1);
        chk("after clr not yet valid", d4_valid, 0);
        tick(7'h07, 1'b1);
        chk("after clr digit", d4_digit, 7);
        chk("after clr valid", d4_valid, 1);

        begin
            logic [6:0] s1 [4];
            int e_dig [4];
            int e_nd [4];
            s1 = '{7'h3F, 7'h06, 7'h06, 7'h7F};
            e_dig = '{0, 1, 1, 8};
            e_nd = '{1, 1, 0, 1};
            for (int t = 0; t < 4; t++) begin
                tick(s1[t], 1'b1);
                chk($sformatf("cnt1 digit t%0d", t), d1_digit, e_dig[t]);
                chk($sformatf("cnt1 new_digit t%0d", t), d1_nd, e_nd[t]);
                chk($sformatf("cnt1 valid t%0d", t), d1_valid, 1);
            end
        end

        begin
            int hold;
            logic [6:0] cur;
            hold = 0;
            cur = 7'd0;
            for (int c = 0; c < 3000; c++) begin
                @(negedge clk_50);
                for (int i = 0; i < 2; i++) begin
                    int a_dig, a_val, a_err, a_nd, a_cnt;
                    a_dig = (i == 0) ? d4_digit : d1_digit;
                    a_val = (i == 0) ? d4_valid : d1_valid;
                    a_err = (i == 0) ? d4_err : d1_err;
                    a_nd  = (i == 0) ? d4_nd : d1_nd;
                    a_cnt = (i == 0) ? d4_cnt : d1_cnt;
                    chk($sformatf("rand c%0d u%0d digit", c, i), a_dig, m_digit[i]);
                    chk($sformatf("rand c%0d u%0d valid", c, i), a_val, m_valid[i]);
                    chk($sformatf("rand c%0d u%0d err", c, i), a_err, m_err[i]);
                    chk($sformatf("rand c%0d u%0d new_digit", c, i), a_nd, m_nd[i]);
                    chk($sformatf("rand c%0d u%0d err_count", c, i), a_cnt, m_cnt[i]);
                end
                if (hold == 0) begin
                    cur = pool[$urandom_range(0, 13)];
                    hold = $urandom_range(1, 7);
                end
                hold--;
                seg_in = cur;
                sample_en = ($urandom_range(0, 3) != 0);
                clr = ($urandom_range(0, 599) != 0);
            end
            @(negedge clk_50);
            clr = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
